// File: rtl/svm_sched_pkg.sv
// Shared types for the scheduler/dispatcher slice: bus widths, the
// dispatch FSM encoding and a lane-mask population count helper.
package svm_sched_pkg;

  localparam int PROGRAM_ID_W = 64;
  localparam int DEP_W        = 1024;

  typedef enum logic [1:0] {
    EMPTY,
    WAIT,
    OFFER
  } disp_state_e;

  // Lane masks are at most 16 wide; callers zero-extend into v.
  function automatic logic [31:0] popcount(input logic [15:0] v);
    popcount = '0;
    for (int i = 0; i < 16; i++) begin
      popcount = popcount + {31'd0, v[i]};
    end
  endfunction

endpackage

// File: rtl/rr_idle_arbiter.sv
// Round-robin pick of the first idle lane at or after rr_ptr.
// Ports: idle mask, rr_ptr in; grant index, any_idle out.
module rr_idle_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    idle,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [ID_W-1:0] grant,
  output logic            any_idle
);

  logic [ID_W-1:0] idx;

  // Scan from farthest to nearest so the nearest idle lane wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any_idle = |idle;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ID_W'((int'(rr_ptr) + i) % N);
      if (idle[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/exec_dispatcher.sv
// Issues upstream transactions to idle execution lanes round-robin and
// tracks lane occupancy until exec_done.
// Ports: s_axis_* upstream handshake + payload; m_exec_* lane offer
// (one-hot valid, shared bus); exec_done per lane; lane_busy and
// 32-bit dispatched/completed/stall/spurious/timeout statistics.
// Build option: DISPATCH_WATCHDOG_EN adds a per-lane busy watchdog
// (EXEC_TIMEOUT_CYCLES); otherwise lane_timeout/timeout_count are 0.
module exec_dispatcher
  import svm_sched_pkg::*;
#(
  parameter  int NUM_LANES           = 4,
  parameter  int MAX_DEPENDENCIES    = DEP_W,
  parameter  int EXEC_TIMEOUT_CYCLES = 1000,
  localparam int LANE_ID_W           = $clog2(NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [PROGRAM_ID_W-1:0]     s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  output logic [NUM_LANES-1:0]        m_exec_tvalid,
  input  logic [NUM_LANES-1:0]        m_exec_tready,
  output logic [LANE_ID_W-1:0]        m_exec_lane,
  output logic [PROGRAM_ID_W-1:0]     m_exec_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0] m_exec_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0] m_exec_tdata_write_dependencies,
  input  logic [NUM_LANES-1:0]        exec_done,
  output logic [NUM_LANES-1:0]        lane_busy,
  output logic [31:0]                 dispatched_count,
  output logic [31:0]                 completed_count,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 spurious_done,
  output logic [NUM_LANES-1:0]        lane_timeout,
  output logic [31:0]                 timeout_count
);

  if (NUM_LANES < 2 || NUM_LANES > 16 || EXEC_TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("exec_dispatcher: parameter out of range");
  end

  disp_state_e state;

  logic [LANE_ID_W-1:0]        grant;
  logic [LANE_ID_W-1:0]        rr_ptr;
  logic [LANE_ID_W-1:0]        arb_grant;
  logic [LANE_ID_W-1:0]        rr_next;
  logic                        any_idle;
  logic [NUM_LANES-1:0]        grant_oh;
  logic [NUM_LANES-1:0]        take_mask;
  logic [NUM_LANES-1:0]        done_hit;
  logic [NUM_LANES-1:0]        done_miss;
  logic [NUM_LANES-1:0]        timeout_hit;
  logic                        take;
  logic                        accept;
  logic [PROGRAM_ID_W-1:0]     hold_pid;
  logic [MAX_DEPENDENCIES-1:0] hold_rd;
  logic [MAX_DEPENDENCIES-1:0] hold_wr;

  rr_idle_arbiter #(
    .N    (NUM_LANES),
    .ID_W (LANE_ID_W)
  ) u_arb (
    .idle     (~lane_busy),
    .rr_ptr   (rr_ptr),
    .grant    (arb_grant),
    .any_idle (any_idle)
  );

  assign grant_oh  = NUM_LANES'(1) << grant;
  assign take      = (state == OFFER) && m_exec_tready[grant];
  assign take_mask = take ? grant_oh : '0;
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign done_hit  = exec_done & lane_busy;
  assign done_miss = exec_done & ~lane_busy;

  assign rr_next = (arb_grant == LANE_ID_W'(NUM_LANES - 1))
                 ? '0 : arb_grant + LANE_ID_W'(1);

  assign s_axis_tready = (state == EMPTY) || take;
  assign m_exec_tvalid = (state == OFFER) ? grant_oh : '0;
  assign m_exec_lane   = grant;

  // The bus shows the holding register, which only reloads on an
  // upstream accept, so it is stable for the life of an offer.
  assign m_exec_tdata_owner_programID    = hold_pid;
  assign m_exec_tdata_read_dependencies  = hold_rd;
  assign m_exec_tdata_write_dependencies = hold_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= EMPTY;
      grant            <= '0;
      rr_ptr           <= '0;
      lane_busy        <= '0;
      hold_pid         <= '0;
      hold_rd          <= '0;
      hold_wr          <= '0;
      dispatched_count <= '0;
      completed_count  <= '0;
      stall_cycles     <= '0;
      spurious_done    <= '0;
    end else begin
      lane_busy <= (lane_busy & ~done_hit & ~timeout_hit) | take_mask;
      completed_count <= completed_count + popcount(16'(done_hit));
      spurious_done   <= spurious_done + popcount(16'(done_miss));
      if (take) dispatched_count <= dispatched_count + 32'd1;
      if (accept) begin
        hold_pid <= s_axis_tdata_owner_programID;
        hold_rd  <= s_axis_tdata_read_dependencies;
        hold_wr  <= s_axis_tdata_write_dependencies;
      end
      unique case (state)
        EMPTY: if (accept) state <= WAIT;
        WAIT: begin
          if (any_idle) begin
            grant  <= arb_grant;
            rr_ptr <= rr_next;
            state  <= OFFER;
          end else begin
            stall_cycles <= stall_cycles + 32'd1;
          end
        end
        OFFER: if (take) state <= accept ? WAIT : EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef DISPATCH_WATCHDOG_EN
  localparam int WD_W = $clog2(EXEC_TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(EXEC_TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt [NUM_LANES];

  // A done arriving on the expiry cycle wins over the timeout.
  always_comb begin
    timeout_hit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      timeout_hit[i] = lane_busy[i] && !exec_done[i] && (wd_cnt[i] == WD_LAST);
    end
  end

  // Counter idles at zero, so it starts from zero when a lane goes busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) wd_cnt[i] <= '0;
      lane_timeout  <= '0;
      timeout_count <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!lane_busy[i]) wd_cnt[i] <= '0;
        else               wd_cnt[i] <= wd_cnt[i] + WD_W'(1);
      end
      lane_timeout  <= timeout_hit;
      timeout_count <= timeout_count + popcount(16'(timeout_hit));
    end
  end
`else
  assign timeout_hit   = '0;
  assign lane_timeout  = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_exec_dispatcher.sv
// Directed, table-driven bench for exec_dispatcher (4 lanes).
// Optional watchdog section follows DISPATCH_WATCHDOG_EN.
module tb_exec_dispatcher;
  import svm_sched_pkg::*;

  localparam int NL = 4;
  localparam int MD = DEP_W;
  localparam int TO = 24;

  logic          clk;
  logic          rst;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [63:0]   s_pid;
  logic [MD-1:0] s_rd;
  logic [MD-1:0] s_wr;
  logic [NL-1:0] m_exec_tvalid;
  logic [NL-1:0] m_exec_tready;
  logic [1:0]    m_exec_lane;
  logic [63:0]   m_pid;
  logic [MD-1:0] m_rd;
  logic [MD-1:0] m_wr;
  logic [NL-1:0] exec_done;
  logic [NL-1:0] lane_busy;
  logic [31:0]   dispatched_count;
  logic [31:0]   completed_count;
  logic [31:0]   stall_cycles;
  logic [31:0]   spurious_done;
  logic [NL-1:0] lane_timeout;
  logic [31:0]   timeout_count;

  int n_pass = 0;
  int n_total = 0;

  exec_dispatcher #(
    .NUM_LANES           (NL),
    .MAX_DEPENDENCIES    (MD),
    .EXEC_TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                             (clk),
    .rst                             (rst),
    .s_axis_tvalid                   (s_axis_tvalid),
    .s_axis_tready                   (s_axis_tready),
    .s_axis_tdata_owner_programID    (s_pid),
    .s_axis_tdata_read_dependencies  (s_rd),
    .s_axis_tdata_write_dependencies (s_wr),
    .m_exec_tvalid                   (m_exec_tvalid),
    .m_exec_tready                   (m_exec_tready),
    .m_exec_lane                     (m_exec_lane),
    .m_exec_tdata_owner_programID    (m_pid),
    .m_exec_tdata_read_dependencies  (m_rd),
    .m_exec_tdata_write_dependencies (m_wr),
    .exec_done                       (exec_done),
    .lane_busy                       (lane_busy),
    .dispatched_count                (dispatched_count),
    .completed_count                 (completed_count),
    .stall_cycles                    (stall_cycles),
    .spurious_done                   (spurious_done),
    .lane_timeout                    (lane_timeout),
    .timeout_count                   (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic [7:0] tag;
    logic [3:0] rdy;
    logic [3:0] done;
    logic       str;
    logic [3:0] tv;
    logic [1:0] ln;
    logic [3:0] busy;
    logic [7:0] dsp;
    logic [7:0] cmp;
    logic [7:0] stl;
    logic [7:0] spu;
    logic [7:0] epid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic sv, input logic [7:0] tag,
    input logic [3:0] rdy, input logic [3:0] done,
    input logic str, input logic [3:0] tv,
    input logic [1:0] ln, input logic [3:0] busy,
    input logic [7:0] dsp, input logic [7:0] cmp,
    input logic [7:0] stl, input logic [7:0] spu,
    input logic [7:0] epid);
    vec_t v;
    v.sv = sv; v.tag = tag; v.rdy = rdy; v.done = done;
    v.str = str; v.tv = tv; v.ln = ln; v.busy = busy;
    v.dsp = dsp; v.cmp = cmp; v.stl = stl; v.spu = spu;
    v.epid = epid;
    return v;
  endfunction

  function automatic logic [63:0] mkpid(input logic [7:0] tag);
    return 64'hC0DE_0000_0000_0000 | 64'(tag);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_bus(input string nm, input logic [7:0] tag);
    logic [63:0] p;
    p = mkpid(tag);
    chk({nm, ".pid"}, m_pid, p);
    chk({nm, ".rd"}, 64'(m_rd === {16{p}}), 64'd1);
    chk({nm, ".wr"}, 64'(m_wr === {16{~p}}), 64'd1);
  endtask

  task automatic drive(input logic sv, input logic [7:0] tag,
                       input logic [3:0] rdy, input logic [3:0] dn);
    s_axis_tvalid = sv;
    s_pid = mkpid(tag);
    s_rd = {16{mkpid(tag)}};
    s_wr = {16{~mkpid(tag)}};
    m_exec_tready = rdy;
    exec_done = dn;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".str"}, 64'(s_axis_tready), 64'd1);
    chk({nm, ".tv"}, 64'(m_exec_tvalid), 64'd0);
    chk({nm, ".ln"}, 64'(m_exec_lane), 64'd0);
    chk({nm, ".busy"}, 64'(lane_busy), 64'd0);
    chk({nm, ".dsp"}, 64'(dispatched_count), 64'd0);
    chk({nm, ".cmp"}, 64'(completed_count), 64'd0);
    chk({nm, ".stl"}, 64'(stall_cycles), 64'd0);
    chk({nm, ".spu"}, 64'(spurious_done), 64'd0);
    chk({nm, ".lto"}, 64'(lane_timeout), 64'd0);
    chk({nm, ".tcnt"}, 64'(timeout_count), 64'd0);
    chk({nm, ".pid"}, m_pid, 64'd0);
  endtask

  initial begin
    // sv tag rdy done | str tv ln busy | dsp cmp stl spu | bus pid
    tbl.push_back(mk(1, 1, 4'hF, 4'h0, 1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 4'hF, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 4'hF, 4'h0, 1, 4'h1, 0, 4'h0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3, 4'hF, 4'h0, 0, 4'h0, 0, 4'h1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 4'hF, 4'h0, 1, 4'h2, 1, 4'h1, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 4, 4'hF, 4'h0, 0, 4'h0, 1, 4'h3, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 4'hF, 4'h0, 1, 4'h4, 2, 4'h3, 2, 0, 0, 0, 3));
    tbl.push_back(mk(1, 5, 4'hF, 4'h0, 0, 4'h0, 2, 4'h7, 3, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 4'hF, 4'h0, 1, 4'h8, 3, 4'h7, 3, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 4'h0, 3, 4'hF, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 4'h0, 3, 4'hF, 4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h4, 0, 4'h0, 3, 4'hF, 4, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 4'h0, 3, 4'hB, 4, 1, 3, 0, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 1, 4'h4, 2, 4'hB, 4, 1, 3, 0, 5));
    tbl.push_back(mk(0, 0, 4'hF, 4'h2, 1, 4'h0, 2, 4'hF, 5, 1, 3, 0, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h2, 1, 4'h0, 2, 4'hD, 5, 2, 3, 0, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h9, 1, 4'h0, 2, 4'hD, 5, 2, 3, 1, 0));
    tbl.push_back(mk(1, 6, 4'hF, 4'h0, 1, 4'h0, 2, 4'h4, 5, 4, 3, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 4'h0, 2, 4'h4, 5, 4, 3, 1, 0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 0, 4'h7, 4'h0, 0, 4'h8, 3, 4'h4, 5, 4, 3, 1, 6));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 1, 4'h8, 3, 4'h4, 5, 4, 3, 1, 6));
    tbl.push_back(mk(1, 7, 4'hF, 4'h0, 1, 4'h0, 3, 4'hC, 6, 4, 3, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 4'h0, 3, 4'hC, 6, 4, 3, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 1, 4'h1, 0, 4'hC, 6, 4, 3, 1, 7));
    tbl.push_back(mk(1, 8, 4'hF, 4'h0, 1, 4'h0, 0, 4'hD, 7, 4, 3, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 4'h0, 0, 4'hD, 7, 4, 3, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 4'h2, 1, 4'hD, 7, 4, 3, 1, 8));

    rst = 1'b1;
    drive(0, 0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    chk_zero("reset");
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("r%0d", i);
      drive(tbl[i].sv, tbl[i].tag, tbl[i].rdy, tbl[i].done);
      #2;
      chk({nm, ".str"}, 64'(s_axis_tready), 64'(tbl[i].str));
      chk({nm, ".tv"}, 64'(m_exec_tvalid), 64'(tbl[i].tv));
      chk({nm, ".ln"}, 64'(m_exec_lane), 64'(tbl[i].ln));
      chk({nm, ".busy"}, 64'(lane_busy), 64'(tbl[i].busy));
      chk({nm, ".dsp"}, 64'(dispatched_count), 64'(tbl[i].dsp));
      chk({nm, ".cmp"}, 64'(completed_count), 64'(tbl[i].cmp));
      chk({nm, ".stl"}, 64'(stall_cycles), 64'(tbl[i].stl));
      chk({nm, ".spu"}, 64'(spurious_done), 64'(tbl[i].spu));
      if (tbl[i].epid != 8'd0) chk_bus(nm, tbl[i].epid);
      @(negedge clk);
    end

    // Reset while offering with three lanes busy.
    rst = 1'b1;
    drive(0, 0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_zero("midrst");
    @(negedge clk);

    // Fresh transaction must land on lane 0 two cycles after accept.
    drive(1, 9, 4'hF, 4'h0);
    #2;
    chk("t9.acc", 64'(s_axis_tready), 64'd1);
    @(negedge clk);
    drive(0, 0, 4'hF, 4'h0);
    #2;
    chk("t9.wait_tv", 64'(m_exec_tvalid), 64'd0);
    @(negedge clk);
    #2;
    chk("t9.tv", 64'(m_exec_tvalid), 64'd1);
    chk("t9.ln", 64'(m_exec_lane), 64'd0);
    chk_bus("t9", 8'd9);
    @(negedge clk);
    #2;
    chk("t9.dsp", 64'(dispatched_count), 64'd1);

`ifdef DISPATCH_WATCHDOG_EN
    for (int k = 0; k < TO; k++) begin
      chk($sformatf("wd%0d.busy", k), 64'(lane_busy), 64'd1);
      chk($sformatf("wd%0d.lto", k), 64'(lane_timeout), 64'd0);
      @(negedge clk);
      #2;
    end
    chk("wd.lto", 64'(lane_timeout), 64'd1);
    chk("wd.busy", 64'(lane_busy), 64'd0);
    chk("wd.tcnt", 64'(timeout_count), 64'd1);
    @(negedge clk);
    drive(0, 0, 4'hF, 4'h1);
    #2;
    chk("wd.lto_end", 64'(lane_timeout), 64'd0);
    @(negedge clk);
    drive(0, 0, 4'hF, 4'h0);
    #2;
    chk("wd.spu", 64'(spurious_done), 64'd1);
    chk("wd.cmp", 64'(completed_count), 64'd0);
`else
    for (int k = 0; k < TO + 6; k++) begin
      chk($sformatf("nowd%0d.busy", k), 64'(lane_busy), 64'd1);
      chk($sformatf("nowd%0d.lto", k), 64'(lane_timeout), 64'd0);
      @(negedge clk);
      #2;
    end
    chk("nowd.tcnt", 64'(timeout_count), 64'd0);
    @(negedge clk);
    drive(0, 0, 4'hF, 4'h1);
    @(negedge clk);
    drive(0, 0, 4'hF, 4'h0);
    #2;
    chk("nowd.cmp", 64'(completed_count), 64'd1);
    chk("nowd.spu", 64'(spurious_done), 64'd0);
    chk("nowd.busy", 64'(lane_busy), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
